// File: rtl/layer3_pixel_buffer.sv
// layer3_pixel_buffer
// Frame store between the layer-2 output writer and the layer-3 2x2 max-pool.
// Captures one IN_WIDTH x IN_WIDTH feature map written in raster order, then
// holds it (pixel_store_done = 1) and serves pooled-coordinate reads, returning
// all four pixels of a 2x2 window in parallel one cycle after the strobe.
//
// Optional feature macro: LAYER3_PIXEL_BUF_BOUNDS_CHECK_EN
//   defined   : out-of-range writes are dropped, out-of-range reads return zeros
//   undefined : no address checking (addresses wrap modulo the array depth)
//
// State table
//   state | meaning
//   FILL  | accepting writes; counting toward a full frame
//   FULL  | frame complete and readable; writes ignored until calc done

`ifndef WORDLENGTH
`define WORDLENGTH 16
`endif

`ifndef LAYER3_WEIGHT_INPUT_LENGTH
`define LAYER3_WEIGHT_INPUT_LENGTH 128
`endif

module layer3_pixel_buffer #(
   parameter int unsigned IN_WIDTH = 16,
   parameter int unsigned DATA_W   = `LAYER3_WEIGHT_INPUT_LENGTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    save_enable,
   input  logic [`WORDLENGTH-1:0]  input_row,
   input  logic [`WORDLENGTH-1:0]  input_col,
   input  logic [DATA_W-1:0]       input_data,
   input  logic                    read_pixel_signal,
   input  logic [`WORDLENGTH-1:0]  read_row_addr,
   input  logic [`WORDLENGTH-1:0]  read_col_addr,
   input  logic                    layer3_calculation_done,
   output logic                    pixel_store_done,
   output logic [DATA_W-1:0]       input_data_even_even,
   output logic [DATA_W-1:0]       input_data_even_odd,
   output logic [DATA_W-1:0]       input_data_odd_even,
   output logic [DATA_W-1:0]       input_data_odd_odd
);

   localparam int unsigned DEPTH  = IN_WIDTH * IN_WIDTH;
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned POOL_W = IN_WIDTH / 2;

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [AW-1:0] ROW_STEP = AW'(IN_WIDTH);
   localparam logic [15:0]   LAST_CNT = 16'(DEPTH - 1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t            state;
   logic [15:0]       wr_count;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr_ee;
   logic [AW-1:0]     rd_addr_eo;
   logic [AW-1:0]     rd_addr_oe;
   logic [AW-1:0]     rd_addr_oo;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_fire;

   // Linear array addresses for the write pixel and the 2x2 read window.
   assign wr_addr    = AW'(32'(input_row) * IN_WIDTH + 32'(input_col));
   assign rd_addr_ee = AW'(32'(read_row_addr) * 2 * IN_WIDTH + 32'(read_col_addr) * 2);
   assign rd_addr_eo = rd_addr_ee + ADDR_ONE;
   assign rd_addr_oe = rd_addr_ee + ROW_STEP;
   assign rd_addr_oo = rd_addr_oe + ADDR_ONE;

`ifdef LAYER3_PIXEL_BUF_BOUNDS_CHECK_EN
   assign wr_in_range = (32'(input_row) < IN_WIDTH) && (32'(input_col) < IN_WIDTH);
   assign rd_in_range = (32'(read_row_addr) < POOL_W) && (32'(read_col_addr) < POOL_W);
`else
   assign wr_in_range = 1'b1;
   assign rd_in_range = 1'b1;
`endif

   // A write only lands (and only counts) while filling.
   assign wr_fire = (state == FILL) && save_enable && wr_in_range;

   // Frame-tracking FSM: write counter and the registered done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= FILL;
         wr_count         <= 16'd0;
         pixel_store_done <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (wr_fire) begin
                  if (wr_count == LAST_CNT) begin
                     state            <= FULL;
                     wr_count         <= 16'd0;
                     pixel_store_done <= 1'b1;
                  end else begin
                     wr_count <= wr_count + 16'd1;
                  end
               end
            end
            FULL: begin
               if (layer3_calculation_done) begin
                  state            <= FILL;
                  pixel_store_done <= 1'b0;
               end
            end
            default: begin
               state            <= FILL;
               wr_count         <= 16'd0;
               pixel_store_done <= 1'b0;
            end
         endcase
      end
   end

   // Pixel array; deliberately unreset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_addr] <= input_data;
      end
   end

   // Window read: registered outputs, hold when not strobed. Reading mem here
   // with non-blocking semantics gives read-before-write on a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         input_data_even_even <= '0;
         input_data_even_odd  <= '0;
         input_data_odd_even  <= '0;
         input_data_odd_odd   <= '0;
      end else if (read_pixel_signal) begin
         if (rd_in_range) begin
            input_data_even_even <= mem[rd_addr_ee];
            input_data_even_odd  <= mem[rd_addr_eo];
            input_data_odd_even  <= mem[rd_addr_oe];
            input_data_odd_odd   <= mem[rd_addr_oo];
         end else begin
            input_data_even_even <= '0;
            input_data_even_odd  <= '0;
            input_data_odd_even  <= '0;
            input_data_odd_odd   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_layer3_pixel_buffer.sv
// Self-checking bench for layer3_pixel_buffer: directed sequence with random
// data/reads, compared against a frame-level reference model.

`ifndef WORDLENGTH
`define WORDLENGTH 16
`endif

module tb_layer3_pixel_buffer;

   localparam int W  = 16;
   localparam int DW = 128;
   localparam int NP = W * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          save_enable = 1'b0;
   logic [15:0]   input_row = '0;
   logic [15:0]   input_col = '0;
   logic [DW-1:0] input_data = '0;
   logic          read_pixel_signal = 1'b0;
   logic [15:0]   read_row_addr = '0;
   logic [15:0]   read_col_addr = '0;
   logic          layer3_calculation_done = 1'b0;
   logic          pixel_store_done;
   logic [DW-1:0] ee, eo, oe, oo;

   layer3_pixel_buffer #(.IN_WIDTH(W), .DATA_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .save_enable(save_enable),
      .input_row(input_row),
      .input_col(input_col),
      .input_data(input_data),
      .read_pixel_signal(read_pixel_signal),
      .read_row_addr(read_row_addr),
      .read_col_addr(read_col_addr),
      .layer3_calculation_done(layer3_calculation_done),
      .pixel_store_done(pixel_store_done),
      .input_data_even_even(ee),
      .input_data_even_odd(eo),
      .input_data_odd_even(oe),
      .input_data_odd_odd(oo)
   );

   always #5 clk = ~clk;

   // reference model: the frame as a plain array plus "how many pixels so far"
   logic [DW-1:0] ref_pix [NP];
   int            ref_writes = 0;
   bit            ref_full   = 1'b0;
   logic [DW-1:0] x_ee = '0, x_eo = '0, x_oe = '0, x_oo = '0;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [DW-1:0] pat(input int row, input int col);
      logic [15:0] v;
      v = 16'(row * 16 + col);
      return {8{v}};
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_ee"}, ee, x_ee);
      check({tag, "_eo"}, eo, x_eo);
      check({tag, "_oe"}, oe, x_oe);
      check({tag, "_oo"}, oo, x_oo);
      check({tag, "_done"}, DW'(pixel_store_done), DW'(ref_full));
   endtask

   // One clock cycle of stimulus; model computed from the frame-level rules.
   task automatic step(input string tag, input bit se, input int row, input int col,
                       input logic [DW-1:0] d, input bit rd, input int r, input int c,
                       input bit cdone);
      if (rd) begin
         if (r >= W / 2 || c >= W / 2) begin
            x_ee = '0; x_eo = '0; x_oe = '0; x_oo = '0;
         end else begin
            x_ee = ref_pix[(2 * r) * W + 2 * c];
            x_eo = ref_pix[(2 * r) * W + 2 * c + 1];
            x_oe = ref_pix[(2 * r + 1) * W + 2 * c];
            x_oo = ref_pix[(2 * r + 1) * W + 2 * c + 1];
         end
      end
      if (ref_full) begin
         if (cdone) ref_full = 1'b0;
      end else if (se && row < W && col < W) begin
         ref_pix[row * W + col] = d;
         ref_writes++;
         if (ref_writes == NP) begin
            ref_full   = 1'b1;
            ref_writes = 0;
         end
      end
      save_enable             = se;
      input_row               = 16'(row);
      input_col               = 16'(col);
      input_data              = d;
      read_pixel_signal       = rd;
      read_row_addr           = 16'(r);
      read_col_addr           = 16'(c);
      layer3_calculation_done = cdone;
      @(posedge clk);
      #1;
      save_enable             = 1'b0;
      read_pixel_signal       = 1'b0;
      layer3_calculation_done = 1'b0;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      ref_writes = 0;
      ref_full   = 1'b0;
      x_ee = '0; x_eo = '0; x_oe = '0; x_oo = '0;
      check_all("reset_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] rnd;
      @(posedge clk);
      #1;
      do_reset();
      check_all("reset_state");

      // frame 1: pattern data in raster order
      for (int i = 0; i < NP; i++) begin
         step("fill1", 1'b1, i / W, i % W, pat(i / W, i % W), 1'b0, 0, 0, 1'b0);
         if (i == NP - 2) check("done_after_254", DW'(pixel_store_done), DW'(0));
         if (i == NP - 1) check("done_after_255", DW'(pixel_store_done), DW'(1));
      end

      // FULL: known windows
      step("rd35", 1'b0, 0, 0, '0, 1'b1, 3, 5, 1'b0);
      check("rd35_ee_const", ee, {8{16'h006A}});
      check("rd35_eo_const", eo, {8{16'h006B}});
      check("rd35_oe_const", oe, {8{16'h007A}});
      check("rd35_oo_const", oo, {8{16'h007B}});
      step("rd00", 1'b0, 0, 0, '0, 1'b1, 0, 0, 1'b0);
      check("rd00_ee_const", ee, {8{16'h0000}});
      step("rd77", 1'b0, 0, 0, '0, 1'b1, 7, 7, 1'b0);
      check("rd77_ee_const", ee, {8{16'h00EE}});
      step("hold", 1'b0, 0, 0, '0, 1'b0, 2, 2, 1'b0);

      // FULL: writes ignored
      step("full_wr", 1'b1, 0, 0, {DW{1'b1}}, 1'b0, 0, 0, 1'b0);
      step("full_rd00", 1'b0, 0, 0, '0, 1'b1, 0, 0, 1'b0);
      check("full_wr_dropped", ee, {8{16'h0000}});

      for (int i = 0; i < 20; i++)
         step("full_rand_rd", 1'b0, 0, 0, '0, 1'b1, int'($urandom_range(7)), int'($urandom_range(7)), 1'b0);

      // release with simultaneous write (dropped)
      step("release", 1'b1, 0, 0, {DW{1'b1}}, 1'b0, 0, 0, 1'b1);
      check("release_done0", DW'(pixel_store_done), DW'(0));

      // frame 2: random data, random reads, collision on the first write
      for (int i = 0; i < NP; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         if (i == 0)
            step("fill2_coll", 1'b1, 0, 0, rnd, 1'b1, 0, 0, 1'b0);
         else
            step("fill2", 1'b1, i / W, i % W, rnd, 1'($urandom_range(1)),
                 int'($urandom_range(7)), int'($urandom_range(7)), 1'b0);
      end
      check("fill2_done", DW'(pixel_store_done), DW'(1));
      for (int i = 0; i < 10; i++)
         step("fill2_rd", 1'b0, 0, 0, '0, 1'b1, int'($urandom_range(7)), int'($urandom_range(7)), 1'b0);

      // frame 3 interrupted by reset after 100 writes
      step("release2", 1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 100; i++)
         step("fill3", 1'b1, i / W, i % W, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, 1'b0);
      step("fill3_rd", 1'b0, 0, 0, '0, 1'b1, 1, 1, 1'b0);
      do_reset();
      for (int i = 0; i < NP; i++) begin
         step("fill4", 1'b1, i / W, i % W, {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(7)), 1'b0);
         if (i == NP - 2) check("fill4_done_early", DW'(pixel_store_done), DW'(0));
      end
      check("fill4_done", DW'(pixel_store_done), DW'(1));

`ifdef LAYER3_PIXEL_BUF_BOUNDS_CHECK_EN
      step("release3", 1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b1);
      step("oob_wr", 1'b1, 0, 16, {DW{1'b1}}, 1'b0, 0, 0, 1'b0);
      step("oob_rd", 1'b0, 0, 0, '0, 1'b1, 8, 0, 1'b0);
      check("oob_rd_zero", ee | eo | oe | oo, '0);
      for (int i = 0; i < NP; i++) begin
         step("fill5", 1'b1, i / W, i % W, pat(i / W, i % W), 1'b0, 0, 0, 1'b0);
         if (i == NP - 2) check("fill5_done_early", DW'(pixel_store_done), DW'(0));
      end
      check("fill5_done", DW'(pixel_store_done), DW'(1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/layer3_pixel_buffer.md
# layer3_pixel_buffer

Frame buffer that sits between the layer-2 output writer and the layer-3 2x2 max-pooling stage. It captures one full input feature map (IN_WIDTH x IN_WIDTH pixels, 8 channels x 16 bit each) written in raster order. It then raises `pixel_store_done` and serves pooled-coordinate reads by returning the four pixels of each 2x2 window in parallel. It is the storage/responder end of the pooling stage's read interface (`read_pixel_signal`, `read_row_addr`, `read_col_addr`).

## Interface
- IN_WIDTH, 16: input feature-map side length; must be even. Pooled side length is IN_WIDTH/2.
- DATA_W, `` `LAYER3_WEIGHT_INPUT_LENGTH `` (128): pixel word width, 8 channels x 16 bit.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- save_enable  in  1  write strobe from the layer-2 writer.
- input_row  in  `` `WORDLENGTH ``  write row, 0..IN_WIDTH-1.
- input_col  in  `` `WORDLENGTH ``  write column, 0..IN_WIDTH-1.
- input_data  in  DATA_W  pixel to store.
- read_pixel_signal  in  1  read strobe from the pooling stage.
- read_row_addr  in  `` `WORDLENGTH ``  pooled row r, 0..IN_WIDTH/2-1.
- read_col_addr  in  `` `WORDLENGTH ``  pooled column c, 0..IN_WIDTH/2-1.
- layer3_calculation_done  in  1  pooling stage finished the frame; releases the buffer.
- pixel_store_done  out  1  level; the frame is complete and readable.
- input_data_even_even  out  DATA_W  pixel[2r][2c].
- input_data_even_odd  out  DATA_W  pixel[2r][2c+1].
- input_data_odd_even  out  DATA_W  pixel[2r+1][2c].
- input_data_odd_odd  out  DATA_W  pixel[2r+1][2c+1].

## Operation
- Storage: IN_WIDTH*IN_WIDTH x DATA_W array, indexed row*IN_WIDTH+col. The array is not reset.
- FSM states: FILL and FULL. Reset state is FILL.
- FILL:
  - `save_enable` = 1 writes `input_data` to [input_row][input_col] and increments the 16-bit write counter.
  - When the counter reaches IN_WIDTH*IN_WIDTH-1 and a write occurs, the FSM moves to FULL and the counter is cleared.
  - Duplicate addresses are counted; the writer owns uniqueness.
- FULL:
  - `pixel_store_done` = 1.
  - `save_enable` is ignored: no array write, no count.
  - `layer3_calculation_done` = 1 returns the FSM to FILL on the next edge. A write in that same cycle is ignored.
- Reads:
  - Serviced in both states whenever `read_pixel_signal` = 1.
  - The four output registers load the window at (2r, 2c).
  - With `read_pixel_signal` = 0 the outputs hold their previous value.
- Read/write collision in FILL at the same address: the read returns the old contents (read-before-write).
- `layer3_calculation_done` in FILL is ignored.

## Timing
- Reset values:
  - All four data outputs = 0.
  - `pixel_store_done` = 0.
  - Write counter = 0; state = FILL.
- Reset mid-fill discards progress: the counter returns to 0 and array contents are stale but are overwritten by the next frame.
- Read latency is 1 cycle: address sampled at edge N, data valid after edge N and stable until the next strobed read. One read per cycle is sustained.
- `pixel_store_done` rises the cycle after the final write's edge and falls the cycle after the edge where `layer3_calculation_done` is sampled.
- Fill time is IN_WIDTH² write cycles minimum, with no back-pressure on the writer.

## Configuration
- `LAYER3_PIXEL_BUF_BOUNDS_CHECK_EN` defined:
  - A write with input_row or input_col >= IN_WIDTH is dropped, with no array write and no count.
  - A read with r or c >= IN_WIDTH/2 loads zeros into all four outputs.
- Macro undefined: no address checking. Out-of-range addresses index the array modulo its depth; behaviour is unspecified and the bench must not exercise it.

## Test plan
- Reset, then 256 raster writes with data = {8{row*16+col}} -> `pixel_store_done` = 1 exactly one cycle after write 255; write 254 alone leaves it 0.
- In FULL, read (r=3, c=5) -> next cycle outputs are {8{0x6A}}, {8{0x6B}}, {8{0x7A}}, {8{0x7B}}. Back-to-back reads (0,0), (7,7) return the windows starting at 0x00 and 0xEE on consecutive cycles.
- In FULL, save_enable with row 0, col 0, data 0xFFFF.. -> a re-read of (0,0) still returns 0x0000 in even_even; the counter is unchanged.
- `layer3_calculation_done` pulse with a simultaneous write -> `pixel_store_done` = 0 next cycle and the write is dropped; a fresh 256-write frame sets `pixel_store_done` again after exactly 256 writes.
- rst asserted after 100 writes -> outputs 0 and `pixel_store_done` 0 immediately; 256 further writes are required for `pixel_store_done`.
- With the macro defined, a write at col 16 is not counted and a read at r=8 returns all-zero outputs. With it undefined, the bench does not drive either case.
